// File: rtl/load_store_unit.sv
// Load/store unit: 512x32 data memory plus memory-mapped board I/O.
// Loads are combinational; stores and synchronisers update on the rising clock edge.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);

  logic [31:0] r_dmem [0:511];
  logic [31:0] r_ledr, r_ledg, r_lcd, r_hex_lo, r_hex_hi;
  logic [31:0] r_sw_s1, r_sw_s2;
  logic [3:0]  r_btn_s1, r_btn_s2;

  logic        w_is_b, w_is_h, w_sgn, w_misaligned, w_wr;
  logic [19:0] w_region;
  logic        w_sel_mem, w_sel_ledr, w_sel_ledg, w_sel_hlo, w_sel_hhi;
  logic        w_sel_lcd, w_sel_sw, w_sel_btn;
  logic [8:0]  w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rword, w_lane;

  assign w_is_b = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
  assign w_is_h = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
  assign w_sgn  = ~i_funct3[2];
  assign w_misaligned = w_is_h ? i_lsu_addr[0] : (w_is_b ? 1'b0 : |i_lsu_addr[1:0]);
  assign o_misaligned = w_misaligned;

  assign w_region   = i_lsu_addr[31:12];
  assign w_sel_mem  = (i_lsu_addr[31:11] == '0);
  assign w_sel_ledr = (w_region == 20'h10000);
  assign w_sel_ledg = (w_region == 20'h10001);
  assign w_sel_hlo  = (w_region == 20'h10002);
  assign w_sel_hhi  = (w_region == 20'h10003);
  assign w_sel_lcd  = (w_region == 20'h10004);
  assign w_sel_sw   = (w_region == 20'h10010);
  assign w_sel_btn  = (w_region == 20'h10011);
  assign w_idx      = i_lsu_addr[10:2];

  assign w_wr = i_reset & i_lsu_wren & ~w_misaligned;

  // Store data is replicated across lanes so the byte enables alone place it.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_st_data;
    if (w_is_b) begin
      w_be    = 4'b0001 << i_lsu_addr[1:0];
      w_wdata = {4{i_st_data[7:0]}};
    end else if (w_is_h) begin
      w_be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_st_data[15:0]}};
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int unsigned i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ledr   <= '0;
      r_ledg   <= '0;
      r_lcd    <= '0;
      r_hex_lo <= '0;
      r_hex_hi <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= i_io_sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= i_io_btn;
      r_btn_s2 <= r_btn_s1;
      if (w_wr && w_sel_ledr) r_ledr   <= merge(r_ledr,   w_wdata, w_be);
      if (w_wr && w_sel_ledg) r_ledg   <= merge(r_ledg,   w_wdata, w_be);
      if (w_wr && w_sel_lcd)  r_lcd    <= merge(r_lcd,    w_wdata, w_be);
      if (w_wr && w_sel_hlo)  r_hex_lo <= merge(r_hex_lo, w_wdata, w_be);
      if (w_wr && w_sel_hhi)  r_hex_hi <= merge(r_hex_hi, w_wdata, w_be);
    end
  end

  // Data memory has no reset; per-lane writes keep it RAM-inferable.
  always_ff @(posedge i_clk) begin
    if (w_wr && w_sel_mem) begin
      for (int unsigned i = 0; i < 4; i++)
        if (w_be[i]) r_dmem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_rword = '0;
    if (w_sel_mem)       w_rword = r_dmem[w_idx];
    else if (w_sel_ledr) w_rword = r_ledr;
    else if (w_sel_ledg) w_rword = r_ledg;
    else if (w_sel_hlo)  w_rword = r_hex_lo;
    else if (w_sel_hhi)  w_rword = r_hex_hi;
    else if (w_sel_lcd)  w_rword = r_lcd;
    else if (w_sel_sw)   w_rword = r_sw_s2;
    else if (w_sel_btn)  w_rword = {28'd0, r_btn_s2};
  end

  assign w_lane = w_rword >> {i_lsu_addr[1:0], 3'b000};

  always_comb begin
    o_ld_data = w_rword;
    if (w_misaligned)
      o_ld_data = '0;
    else if (w_is_b)
      o_ld_data = {{24{w_sgn & w_lane[7]}}, w_lane[7:0]};
    else if (w_is_h)
      o_ld_data = {{16{w_sgn & w_lane[15]}}, w_lane[15:0]};
  end

  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = r_lcd;
  assign o_io_hex0 = r_hex_lo[6:0];
  assign o_io_hex1 = r_hex_lo[14:8];
  assign o_io_hex2 = r_hex_lo[22:16];
  assign o_io_hex3 = r_hex_lo[30:24];
  assign o_io_hex4 = r_hex_hi[6:0];
  assign o_io_hex5 = r_hex_hi[14:8];
  assign o_io_hex6 = r_hex_hi[22:16];
  assign o_io_hex7 = r_hex_hi[30:24];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, st_data, sw;
  logic        wren;
  logic [2:0]  f3;
  logic [3:0]  btn;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic        mis;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk(clk), .i_reset(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
    .i_lsu_wren(wren), .i_funct3(f3), .o_ld_data(ld_data), .o_misaligned(mis),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .i_io_sw(sw), .i_io_btn(btn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] f, input logic we,
                       input logic [31:0] d);
    addr = a; f3 = f; wren = we; st_data = d;
    #1;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] exp);
    drive(a, f, 1'b0, '0);
    chk(tag, ld_data, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    drive(a, f, 1'b1, d);
    tick();
    wren = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; btn = '0;
    drive(32'h0, F_W, 1'b0, '0);
    tick(); tick();

    // Reset state: every output register clear, all I/O reads zero (still in reset)
    chk("rst_ledr", ledr, 0);
    chk("rst_ledg", ledg, 0);
    chk("rst_lcd", lcd, 0);
    chk("rst_hex", {hex7, hex6, hex5, hex4} ^ {hex3, hex2, hex1, hex0}, 0);
    chk("rst_hex_or", 32'(hex0 | hex1 | hex2 | hex3 | hex4 | hex5 | hex6 | hex7), 0);
    load("rst_ld_ledr", 32'h1000_0000, F_W, 0);
    load("rst_ld_ledg", 32'h1000_1000, F_W, 0);
    load("rst_ld_hlo",  32'h1000_2000, F_W, 0);
    load("rst_ld_hhi",  32'h1000_3000, F_W, 0);
    load("rst_ld_lcd",  32'h1000_4000, F_W, 0);
    load("rst_ld_sw",   32'h1001_0000, F_W, 0);
    load("rst_ld_btn",  32'h1001_1000, F_W, 0);
    rst_n = 1'b1;
    tick();

    // Word store then sized loads
    store(32'h100, F_W, 32'hDEADBEEF);
    load("lw_100",  32'h100, F_W,  32'hDEADBEEF);
    load("lb_100",  32'h100, F_B,  32'hFFFFFFEF);
    load("lbu_103", 32'h103, F_BU, 32'h000000DE);
    load("lh_102",  32'h102, F_H,  32'hFFFFDEAD);
    load("lhu_102", 32'h102, F_HU, 32'h0000DEAD);
    load("lb_101",  32'h101, F_B,  32'hFFFFFFBE);
    chk("aligned_mis", 32'(mis), 0);

    store(32'h101, F_B, 32'h00000055);
    load("sb_lw_100", 32'h100, F_W, 32'hDEAD55EF);

    // Misaligned accesses: flag, zero load, store suppressed
    drive(32'h101, F_H, 1'b1, 32'h00001234);
    chk("sh101_mis", 32'(mis), 1);
    chk("sh101_ld", ld_data, 0);
    tick();
    drive(32'h102, F_W, 1'b1, 32'h11111111);
    chk("sw102_mis", 32'(mis), 1);
    chk("sw102_ld", ld_data, 0);
    tick();
    load("mis_unch", 32'h100, F_W, 32'hDEAD55EF);
    load("lhu_103_mis", 32'h103, F_HU, 0);
    chk("lhu_103_flag", 32'(mis), 1);

    // Switch synchroniser latency and read-only region
    drive(32'h1001_0000, F_W, 1'b0, '0);
    sw = 32'h0000_00A5;
    tick();
    chk("sw_1edge", ld_data, 0);
    tick();
    chk("sw_2edge", ld_data, 32'hA5);
    store(32'h1001_0000, F_W, 32'hFFFFFFFF);
    load("sw_ro", 32'h1001_0000, F_W, 32'hA5);
    load("sw_alias", 32'h1001_0FFC, F_W, 32'hA5);
    btn = 4'hA;
    tick(); tick();
    load("btn", 32'h1001_1000, F_W, 32'h0000000A);

    // HEX and other output registers
    store(32'h1000_2000, F_W, 32'h00007F3F);
    chk("hex0", 32'(hex0), 32'h3F);
    chk("hex1", 32'(hex1), 32'h7F);
    chk("hex2", 32'(hex2), 0);
    chk("hex3", 32'(hex3), 0);
    load("hex_rb", 32'h1000_2000, F_W, 32'h00007F3F);
    store(32'h1000_3001, F_B, 32'h00000012);
    chk("hex5", 32'(hex5), 32'h12);
    chk("hex4", 32'(hex4), 0);
    store(32'h1000_0000, F_W, 32'h12345678);
    chk("ledr", ledr, 32'h12345678);
    store(32'h1000_1002, F_H, 32'h0000ABCD);
    chk("ledg_h", ledg, 32'hABCD0000);
    store(32'h1000_4000, F_W, 32'hCAFEF00D);
    chk("lcd", lcd, 32'hCAFEF00D);
    load("lcd_lh", 32'h1000_4002, F_H, 32'hFFFFCAFE);

    // Unmapped addresses
    store(32'h0000_0800, F_W, 32'h5A5A5A5A);
    load("unmap_800", 32'h0000_0800, F_W, 0);
    load("unmap_2000", 32'h2000_0000, F_W, 0);
    load("mem_0_unch", 32'h100, F_W, 32'hDEAD55EF);

    // Reset with a store pending: HEX cleared, store has no effect
    rst_n = 1'b0;
    drive(32'h1000_2000, F_W, 1'b1, 32'hFFFFFFFF);
    tick();
    chk("rst2_hex_lo", 32'({hex3, hex2, hex1, hex0}), 0);
    chk("rst2_hex_hi", 32'({hex7, hex6, hex5, hex4}), 0);
    chk("rst2_ledr", ledr, 0);
    drive(32'h100, F_W, 1'b1, 32'h0);
    chk("rst_ld_comb", ld_data, 32'hDEAD55EF);
    tick();
    wren = 1'b0;
    load("rst_mem_keep", 32'h100, F_W, 32'hDEAD55EF);
    rst_n = 1'b1;
    tick();
    load("post_rst_hex", 32'h1000_2000, F_W, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port i_lsu_addr, input, 32, byte address of load/store.
REQ-004 SHALL have port i_st_data, input, 32, store data, right-aligned.
REQ-005 SHALL have port i_lsu_wren, input, 1, store enable; 0 means load.
REQ-006 SHALL have port i_funct3, input, 3, access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W.
REQ-007 SHALL have port o_ld_data, output, 32, aligned and extended load data, feeding the writeback select mux.
REQ-008 SHALL have port o_misaligned, output, 1, combinational flag for the current access.
REQ-009 SHALL have ports o_io_ledr, o_io_ledg, o_io_lcd, output, 32 each, memory-mapped output registers.
REQ-010 SHALL have ports o_io_hex0..o_io_hex7, output, 7 each, seven-segment registers.
REQ-011 SHALL have ports i_io_sw, input, 32, and i_io_btn, input, 4, asynchronous board inputs.

Function
REQ-012 SHALL decode the address map as follows:
- 0x0000_0000-0x0000_07FF: data memory, 512x32.
- 0x1000_0000: LEDR.
- 0x1000_1000: LEDG.
- 0x1000_2000: HEX3..0, byte n bits[6:0].
- 0x1000_3000: HEX7..4.
- 0x1000_4000: LCD.
- 0x1001_0000: SW, read-only.
- 0x1001_1000: BTN, read-only, bits[3:0].
- Each I/O region is 4 KiB; the word is selected by the offset with addr[11:2] ignored.
REQ-013 SHALL return loads combinationally in the same cycle (single-cycle core); o_ld_data is a function of the current address, funct3 and current state.
REQ-014 SHALL perform stores at the rising edge when i_lsu_wren=1, only to the addressed byte lanes.
REQ-015 SHALL select lanes as follows:
- B: lane addr[1:0].
- H: lanes {addr[1],0} and {addr[1],1}.
- W: all four lanes.
REQ-016 SHALL sign-extend B/H loads from the selected byte/half; BU/HU SHALL zero-extend.
REQ-017 SHALL flag an access as misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-018 SHALL respond to a misaligned access as follows: o_misaligned=1, store suppressed, o_ld_data=0.
REQ-019 SHALL respond to an access to an unmapped address as follows: load returns 0, store ignored, o_misaligned follows REQ-017.
REQ-020 SHALL ignore stores to SW/BTN addresses, with no side effect.
REQ-021 SHALL synchronise i_io_sw and i_io_btn through two flip-flop stages; a load SHALL see an input change on the 2nd rising edge after it is applied.
REQ-022 SHALL allow an I/O output register to be read back; a load SHALL return the value written at the previous edge.
REQ-023 SHALL make a load in the cycle following a store to the same address return the new data, with no bypass required.
REQ-024 SHALL drive o_io_hex registers directly from register bits, with no decoding.

Reset
REQ-025 SHALL, when i_reset=0 at a rising edge, clear all I/O output registers and both synchroniser stages to 0.
REQ-026 SHALL leave data memory contents uninitialised by reset.
REQ-027 SHALL block stores while i_reset=0; a store asserted in the same cycle as reset SHALL have no effect.
REQ-028 SHALL continue to evaluate o_ld_data and o_misaligned combinationally during reset.

Verification
REQ-029 SHALL verify: reset, then read all I/O addresses -> every output port 0, o_ld_data 0.
REQ-030 SHALL verify: SW W 0xDEADBEEF to 0x100, then LW 0x100 -> 0xDEADBEEF; LB 0x100 -> 0xFFFFFFEF; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
REQ-031 SHALL verify: SB 0x55 to 0x101 over word 0xDEADBEEF -> LW 0x100 = 0xDEAD55EF.
REQ-032 SHALL verify: SH to 0x101 and SW to 0x102 -> o_misaligned=1, memory unchanged, o_ld_data=0.
REQ-033 SHALL verify: i_io_sw=0x0000_00A5 applied -> LW 0x1001_0000 returns 0 after 1 edge and 0xA5 after 2 edges; SW to 0x1001_0000 has no effect.
REQ-034 SHALL verify: SW 0x0000_7F3F to 0x1000_2000 -> o_io_hex0=0x3F, o_io_hex1=0x7F, o_io_hex2=0, o_io_hex3=0; then reset with i_lsu_wren=1 -> all HEX outputs 0.
